// File: rtl/mvm_job_scheduler.sv
// rtl/mvm_job_scheduler.sv - queues matrix-vector jobs and sequences the array controller one job at a time
// Optional watchdog: define JOB_WDT_EN to enable the per-job TIMEOUT_CYC watchdog and err_timeout.
module mvm_job_scheduler #(
  parameter int SIZE_W      = 8,
  parameter int PE_NUMBER   = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          job_valid,
  output logic                          job_ready,
  input  logic [SIZE_W-1:0]             job_rows,
  input  logic [SIZE_W-1:0]             job_cols,
  output logic                          run_req,
  output logic [SIZE_W-1:0]             row_size,
  output logic [SIZE_W-1:0]             column_size,
  input  logic                          ctrl_busy,
  input  logic                          ctrl_done,
  input  logic                          err_clr,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   jobs_pending,
  output logic [15:0]                   done_cnt,
  output logic                          irq,
  output logic                          err_size,
  output logic                          err_timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [SIZE_W:0] PE_MAX = (SIZE_W+1)'(PE_NUMBER);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t               state_q, state_d;

  logic [2*SIZE_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push, pop;

  logic [SIZE_W-1:0]    row_size_q, col_size_q;
  logic [15:0]          done_cnt_q;
  logic                 err_size_q;
  logic                 err_size_set;
  logic                 job_illegal;

  // Full queue refuses new jobs even if the head is leaving this cycle.
  assign job_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push      = job_valid & job_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  // Descriptor storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {job_rows, job_cols};
    end
  end

  // Queue pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head descriptor is latched on pop and held for the whole job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_size_q <= '0;
      col_size_q <= '0;
    end else if (pop) begin
      {row_size_q, col_size_q} <= mem_q[rd_ptr_q];
    end
  end

  // Zero-sized jobs and jobs taller than the PE column cannot be run.
  assign job_illegal = (row_size_q == '0) || (col_size_q == '0) ||
                       ({1'b0, row_size_q} > PE_MAX);

`ifdef JOB_WDT_EN
  localparam int WDT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [WDT_W-1:0] wdt_q;
  logic             wdt_expired;
  logic             err_to_set;
  logic             err_to_q;

  assign wdt_expired = (wdt_q == WDT_W'(TIMEOUT_CYC - 1));

  // Watchdog counts cycles spent in the current START or RUN visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else if (state_d != state_q) begin
      wdt_q <= '0;
    end else if ((state_q == S_START) || (state_q == S_RUN)) begin
      wdt_q <= wdt_q + 1'b1;
    end
  end

  // Sticky timeout flag; a new timeout beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_to_q <= 1'b0;
    end else begin
      err_to_q <= err_to_set | (err_to_q & ~err_clr);
    end
  end

  assign err_timeout = err_to_q;
`else
  assign err_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; run_req and irq decode straight from state.
  always_comb begin
    state_d      = state_q;
    run_req      = 1'b0;
    irq          = 1'b0;
    err_size_set = 1'b0;
`ifdef JOB_WDT_EN
    err_to_set   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (job_illegal) begin
          err_size_set = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        run_req = 1'b1;
        if (ctrl_busy) begin
          state_d = S_RUN;
        end
`ifdef JOB_WDT_EN
        else if (wdt_expired) begin
          err_to_set = 1'b1;
          state_d    = S_ERR;
        end
`endif
      end
      S_RUN: begin
        if (ctrl_done) begin
          state_d = S_DONE;
        end
`ifdef JOB_WDT_EN
        else if (wdt_expired) begin
          err_to_set = 1'b1;
          state_d    = S_ERR;
        end
`endif
      end
      S_DONE: begin
        irq     = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Completion counter advances once per DONE visit and wraps at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (state_q == S_DONE) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  // Sticky size-error flag; a new discard beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_size_q <= 1'b0;
    end else begin
      err_size_q <= err_size_set | (err_size_q & ~err_clr);
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign jobs_pending = count_q;
  assign row_size     = row_size_q;
  assign column_size  = col_size_q;
  assign done_cnt     = done_cnt_q;
  assign err_size     = err_size_q;

endmodule
